rainbow_sequencer: RTL and testbench
====================================

# rainbow_sequencer

Parametrised successor to the fixed-rate rainbow fade top level. It walks the RGB LED through a continuous six-segment hue wheel and drives three PWM channels. Parameters set PWM resolution, PWM clock prescale, hue step rate and output polarity. Run-time inputs pause the wheel and reverse its direction. It sits directly under the board top level, and its outputs drive the RGB LED pins.

## Interface
- `PWM_BITS`, default 8: duty resolution; `MAX = 2**PWM_BITS-1`; one PWM period is `2**PWM_BITS` PWM ticks.
- `PWM_PRESCALE`, default 5: clocks per PWM tick (≥1). At 12 MHz this gives about a 107 µs period.
- `STEP_DIV`, default 7812: clocks per hue-level step (≥1). One segment lasts `(MAX+1)*STEP_DIV` clocks.
- `ACTIVE_LOW`, default 1: when 1, an LED-on channel drives 0.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: when 1, the hue wheel advances; when 0, it holds. PWM keeps running in both cases.
- `dir` input, 1 bit: 0 = forward (segment 0→5), 1 = reverse.
- `RGB_R`, `RGB_G`, `RGB_B` outputs, 1 bit each: registered LED drive.
- `hue_seg` output, 3 bits: current segment, 0..5.
- `hue_lvl` output, `PWM_BITS` bits: current ramp level.
- `seg_wrap` output, 1 bit: one-clock pulse when the wheel wraps.

## Operation
- **PWM timebase.**
  - The prescaler counts 0..`PWM_PRESCALE-1` and emits `pwm_tick` at its terminal count.
  - `pwm_cnt` (`PWM_BITS` wide) increments on each `pwm_tick` and wraps `MAX`→0.
- **Step timebase.**
  - `step_cnt` counts 0..`STEP_DIV-1` only while `en`=1, and holds its value while `en`=0.
  - `step_tick` = (`step_cnt` == `STEP_DIV-1`) && `en`.
- **Hue state** is (`seg`, `lvl`), updated on `step_tick` only.
  - Forward: if `lvl`<`MAX`, then `lvl`++. Otherwise `lvl`←0 and `seg`←(`seg`==5 ? 0 : `seg`+1).
  - Reverse: if `lvl`>0, then `lvl`--. Otherwise `lvl`←`MAX` and `seg`←(`seg`==0 ? 5 : `seg`-1).
  - `dir` is sampled at each `step_tick`. A change of `dir` mid-segment therefore takes effect at the next tick with no colour jump.
- **Channel modes per segment** (R/G/B):
  - seg 0: FULL / RISE / OFF
  - seg 1: FALL / FULL / OFF
  - seg 2: OFF / FULL / RISE
  - seg 3: OFF / FALL / FULL
  - seg 4: RISE / OFF / FULL
  - seg 5: FULL / OFF / FALL
- **Duty per mode:**
  - OFF → never on.
  - FULL → always on.
  - RISE → on when `pwm_cnt` < `lvl`.
  - FALL → on when `pwm_cnt` < `MAX-lvl`.
  - RISE/FALL therefore reach at most `MAX`/(`MAX+1`) duty.
  - Segment boundaries are colour-continuous in both directions.
- **Output:** `RGB_x` ← `on_x` ^ `ACTIVE_LOW`.
- **`seg_wrap`:** high for the single clock in which `seg` transitions 5→0 (forward) or 0→5 (reverse).
- **Width rules:** all counters are unsigned and wrap explicitly as stated. There is no arithmetic overflow; `MAX-lvl` fits in `PWM_BITS`.

## Timing
- **Reset values (asynchronous, while `rst_n`=0):**
  - All counters = 0.
  - `seg`=0, `lvl`=0.
  - `RGB_R`/`RGB_G`/`RGB_B` = `ACTIVE_LOW` (all LEDs off).
  - `hue_seg`=0, `hue_lvl`=0, `seg_wrap`=0.
- **Reset mid-operation:** the reset state is entered immediately with no clock needed. Operation restarts from segment 0, level 0.
- **`RGB_x` latency:** each `RGB_x` is registered from the current `pwm_cnt`/`seg`/`lvl`, so it lags them by 1 clk.
- **After reset release:** the first clock edge loads the segment 0 drive: R on, G off (`lvl`=0), B off.
- **Status outputs:** `hue_seg`/`hue_lvl` are the state registers themselves. They update on the `step_tick` edge, and `seg_wrap` asserts on that same edge.
- **`en` timing:**
  - `en` falling on the clock where `step_tick` would fire suppresses that tick.
  - On resume, counting continues from the held `step_cnt`.
- **Full wheel length:** `6*(MAX+1)*STEP_DIV` clocks with `en` held at 1.

## Structure
- **Package `rainbow_pkg`:**
  - `seg_t` (3-bit logic).
  - enum `chan_mode_t` {`OFF`, `FULL`, `RISE`, `FALL`}.
  - constant `NUM_SEGS`=6.
  - function `seg_modes(seg_t)`, returning the three channel modes.
- **Sub-module `pwm_channel`** (param `PWM_BITS`; inputs `mode`, `lvl`, `pwm_cnt`; output `on`): combinational duty compare, instantiated three times.
- **Top of block:** prescaler, step divider, hue FSM, output registers.

## Test plan
All scenarios use `PWM_BITS`=2, `PWM_PRESCALE`=1, `STEP_DIV`=4, `ACTIVE_LOW`=1, `en`=1, `dir`=0 unless stated.
- **Reset.**
  - Stimulus: hold `rst_n`=0, then release.
  - Required: during reset `RGB`=111, `hue_seg`=0, `hue_lvl`=0.
  - Required: after the first edge, `RGB_R`=0, `RGB_G`=1, `RGB_B`=1.
- **Forward sequencing.**
  - Required: `hue_lvl` steps 1,2,3 at edges 4, 8, 12.
  - Required: `hue_seg`=1 at edge 16.
  - Required: at edge 96, `hue_seg`=0 and `seg_wrap` is high for exactly 1 clk.
- **Duty.**
  - Stimulus: segment 0, `lvl`=2.
  - Required: `RGB_G` is low for 2 of every 4 clocks, `RGB_R` is constantly 0, `RGB_B` is constantly 1.
- **Reverse.**
  - Stimulus: set `dir`=1 at `seg`=1, `lvl`=1.
  - Required: the next ticks give `lvl`=0, then `seg`=0 with `lvl`=3, then `lvl`=2.
  - Required: continuing reverse, the 0→5 transition pulses `seg_wrap`.
- **Pause.**
  - Stimulus: drop `en` for 10 clocks mid-segment.
  - Required: `hue_lvl` and `hue_seg` are frozen; `RGB_G` PWM continues toggling.
  - Required: the next step occurs at the remaining `STEP_DIV` count after `en` returns.
- **Asynchronous reset mid-run.**
  - Stimulus: pulse `rst_n` low between clock edges at `seg`=3.
  - Required: outputs go to 111 and state clears before the next edge.
  - Required: the sequence restarts at segment 0.

Source files
------------

// File: rtl/rainbow_sequencer_pkg.sv
// Shared types for the rainbow hue-wheel sequencer: segment index,
// per-channel drive mode and the segment -> channel-mode table.
package rainbow_pkg;

  typedef logic [2:0] seg_t;

  typedef enum logic [1:0] {OFF, FULL, RISE, FALL} chan_mode_t;

  localparam int NUM_SEGS = 6;

  typedef struct packed {
    chan_mode_t r;
    chan_mode_t g;
    chan_mode_t b;
  } seg_modes_t;

  // Adjacent segments hand over a channel at equal duty, so the wheel is
  // colour-continuous in both directions.
  function automatic seg_modes_t seg_modes(input seg_t seg);
    seg_modes_t m;
    case (seg)
      3'd0:    m = '{r: FULL, g: RISE, b: OFF };
      3'd1:    m = '{r: FALL, g: FULL, b: OFF };
      3'd2:    m = '{r: OFF,  g: FULL, b: RISE};
      3'd3:    m = '{r: OFF,  g: FALL, b: FULL};
      3'd4:    m = '{r: RISE, g: OFF,  b: FULL};
      3'd5:    m = '{r: FULL, g: OFF,  b: FALL};
      default: m = '{r: OFF,  g: OFF,  b: OFF };
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rainbow_sequencer_if.sv
// Control inputs and LED/status outputs of the rainbow sequencer.
// The master side (board top / bench) drives en and dir; the slave side
// (the sequencer) drives the LED pins and the hue status.
interface rainbow_sequencer_if
  import rainbow_pkg::*;
#(
  parameter int PWM_BITS = 8
);
  logic                en;
  logic                dir;
  logic                RGB_R;
  logic                RGB_G;
  logic                RGB_B;
  seg_t                hue_seg;
  logic [PWM_BITS-1:0] hue_lvl;
  logic                seg_wrap;

  modport master (
    output en, dir,
    input  RGB_R, RGB_G, RGB_B, hue_seg, hue_lvl, seg_wrap
  );

  modport slave (
    input  en, dir,
    output RGB_R, RGB_G, RGB_B, hue_seg, hue_lvl, seg_wrap
  );
endinterface

// File: rtl/rainbow_sequencer_pwm_channel.sv
// Combinational duty compare for one LED channel. RISE/FALL top out at
// MAX/(MAX+1) duty; only FULL is continuously on.
module pwm_channel
  import rainbow_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  chan_mode_t          mode,
  input  logic [PWM_BITS-1:0] lvl,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                on
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  // Compare the running PWM count against the level (or its complement).
  always_comb begin
    on = 1'b0;
    unique case (mode)
      OFF:     on = 1'b0;
      FULL:    on = 1'b1;
      RISE:    on = (pwm_cnt < lvl);
      FALL:    on = (pwm_cnt < (MAX - lvl));
      default: on = 1'b0;
    endcase
  end

endmodule

// File: rtl/rainbow_sequencer.sv
// Rainbow hue-wheel sequencer: PWM prescaler and counter, hue step divider,
// six-segment hue state and registered RGB LED drive.
module rainbow_sequencer
  import rainbow_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PWM_PRESCALE = 5,
  parameter int STEP_DIV     = 7812,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  rainbow_sequencer_if.slave bus
);

  localparam int PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_PRESCALE - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam seg_t                SEG_LAST  = seg_t'(NUM_SEGS - 1);

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [STEP_W-1:0]   r_step;
  seg_t                r_seg;
  logic [PWM_BITS-1:0] r_lvl;
  logic                r_wrap;
  logic                r_rgb_r;
  logic                r_rgb_g;
  logic                r_rgb_b;

  logic       w_pwm_tick;
  logic       w_step_tick;
  logic       w_fwd_wrap;
  logic       w_rev_wrap;
  seg_modes_t w_modes;
  logic       w_on_r;
  logic       w_on_g;
  logic       w_on_b;

  assign w_pwm_tick  = (r_pre == PRE_LAST);
  assign w_step_tick = (r_step == STEP_LAST) && bus.en;
  assign w_fwd_wrap  = (r_seg == SEG_LAST) && (r_lvl == MAX);
  assign w_rev_wrap  = (r_seg == '0) && (r_lvl == '0);
  assign w_modes     = seg_modes(r_seg);

  // Prescaler divides clk down to PWM ticks; the PWM counter wraps MAX -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
    end else if (w_pwm_tick) begin
      r_pre     <= '0;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end else begin
      r_pre     <= r_pre + 1'b1;
    end
  end

  // Step divider only counts while enabled, so a pause resumes mid-count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= '0;
    end else if (bus.en) begin
      r_step <= (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
    end
  end

  // Hue state walks the wheel one level per step tick in the sampled direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg  <= '0;
      r_lvl  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step_tick && (bus.dir ? w_rev_wrap : w_fwd_wrap);
      if (w_step_tick) begin
        if (!bus.dir) begin
          if (r_lvl != MAX) begin
            r_lvl <= r_lvl + 1'b1;
          end else begin
            r_lvl <= '0;
            r_seg <= (r_seg == SEG_LAST) ? '0 : r_seg + 1'b1;
          end
        end else begin
          if (r_lvl != '0) begin
            r_lvl <= r_lvl - 1'b1;
          end else begin
            r_lvl <= MAX;
            r_seg <= (r_seg == '0) ? SEG_LAST : r_seg - 1'b1;
          end
        end
      end
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_chan_r (
    .mode    (w_modes.r),
    .lvl     (r_lvl),
    .pwm_cnt (r_pwm_cnt),
    .on      (w_on_r)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_chan_g (
    .mode    (w_modes.g),
    .lvl     (r_lvl),
    .pwm_cnt (r_pwm_cnt),
    .on      (w_on_g)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_chan_b (
    .mode    (w_modes.b),
    .lvl     (r_lvl),
    .pwm_cnt (r_pwm_cnt),
    .on      (w_on_b)
  );

  // LED pins are registered and polarity-adjusted; reset leaves all LEDs dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_r <= ACTIVE_LOW;
      r_rgb_g <= ACTIVE_LOW;
      r_rgb_b <= ACTIVE_LOW;
    end else begin
      r_rgb_r <= w_on_r ^ ACTIVE_LOW;
      r_rgb_g <= w_on_g ^ ACTIVE_LOW;
      r_rgb_b <= w_on_b ^ ACTIVE_LOW;
    end
  end

  assign bus.RGB_R    = r_rgb_r;
  assign bus.RGB_G    = r_rgb_g;
  assign bus.RGB_B    = r_rgb_b;
  assign bus.hue_seg  = r_seg;
  assign bus.hue_lvl  = r_lvl;
  assign bus.seg_wrap = r_wrap;

endmodule

// File: tb/tb_rainbow_sequencer.sv
// Bench for rainbow_sequencer with a small configuration. The reference
// treats the wheel as a single hue position 0..6*LV-1 and each channel as a
// trapezoid of that position, shifted by two segments per colour.
module tb_rainbow_sequencer;

  localparam int  PB    = 2;
  localparam int  PS    = 1;
  localparam int  SD    = 4;
  localparam bit  AL    = 1'b1;
  localparam int  LV    = 1 << PB;
  localparam int  POS_N = 6 * LV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  rainbow_sequencer_if #(.PWM_BITS(PB)) bus ();

  rainbow_sequencer #(
    .PWM_BITS     (PB),
    .PWM_PRESCALE (PS),
    .STEP_DIV     (SD),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int m_pos;
  int m_en_cnt;
  int m_clk;

  logic [2:0] exp_rgb;
  logic       exp_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Brightness (on-counts per PWM period) of a trapezoid channel at phase s.
  function automatic int shape(input int s, input int l);
    case (s)
      0:       return l;
      1, 2:    return LV;
      3:       return LV - 1 - l;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] drive(input int pos, input int pwm);
    int   seg;
    int   lvl;
    logic r;
    logic g;
    logic b;
    seg = pos / LV;
    lvl = pos % LV;
    r = (pwm < shape((seg + 2) % 6, lvl));
    g = (pwm < shape(seg, lvl));
    b = (pwm < shape((seg + 4) % 6, lvl));
    return {r, g, b} ^ {3{AL}};
  endfunction

  task automatic model_reset();
    m_pos    = 0;
    m_en_cnt = 0;
    m_clk    = 0;
  endtask

  task automatic step();
    exp_rgb  = drive(m_pos, (m_clk / PS) % LV);
    exp_wrap = 1'b0;
    if (bus.en) begin
      if ((m_en_cnt % SD) == SD - 1) begin
        if (!bus.dir) begin
          exp_wrap = (m_pos == POS_N - 1);
          m_pos    = (m_pos + 1) % POS_N;
        end else begin
          exp_wrap = (m_pos == 0);
          m_pos    = (m_pos + POS_N - 1) % POS_N;
        end
      end
      m_en_cnt++;
    end
    m_clk++;
    @(posedge clk);
    #1;
    chk("rgb",  32'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 32'(exp_rgb));
    chk("seg",  32'(bus.hue_seg), 32'(m_pos / LV));
    chk("lvl",  32'(bus.hue_lvl), 32'(m_pos % LV));
    chk("wrap", 32'(bus.seg_wrap), 32'(exp_wrap));
  endtask

  function automatic logic [31:0] rgb_now();
    return 32'({bus.RGB_R, bus.RGB_G, bus.RGB_B});
  endfunction

  initial begin
    int g_low;
    int r_low;
    int b_high;
    int wraps;
    int g_on;
    int g_off;
    int guard;

    bus.en  = 1'b1;
    bus.dir = 1'b0;
    model_reset();

    // Reset held: all LEDs dark, hue at origin.
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb",  rgb_now(), 32'h7);
    chk("rst_seg",  32'(bus.hue_seg), 32'd0);
    chk("rst_lvl",  32'(bus.hue_lvl), 32'd0);
    chk("rst_wrap", 32'(bus.seg_wrap), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Forward sequencing through a full wheel.
    for (int e = 1; e <= 100; e++) begin
      step();
      if (e == 1)  chk("first_rgb", rgb_now(), 32'h3);
      if (e == 4)  chk("e4_lvl",  32'(bus.hue_lvl), 32'd1);
      if (e == 8)  chk("e8_lvl",  32'(bus.hue_lvl), 32'd2);
      if (e == 12) chk("e12_lvl", 32'(bus.hue_lvl), 32'd3);
      if (e == 16) chk("e16_seg", 32'(bus.hue_seg), 32'd1);
      if (e == 95) chk("e95_wrap", 32'(bus.seg_wrap), 32'd0);
      if (e == 96) begin
        chk("e96_seg",  32'(bus.hue_seg), 32'd0);
        chk("e96_wrap", 32'(bus.seg_wrap), 32'd1);
      end
      if (e == 97) chk("e97_wrap", 32'(bus.seg_wrap), 32'd0);
    end

    // Duty at segment 0, level 2.
    repeat (4) step();
    g_low = 0; r_low = 0; b_high = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.RGB_G == 1'b0) g_low++;
      if (bus.RGB_R == 1'b0) r_low++;
      if (bus.RGB_B == 1'b1) b_high++;
    end
    chk("duty_g_low",  32'(g_low),  32'd2);
    chk("duty_r_low",  32'(r_low),  32'd4);
    chk("duty_b_high", 32'(b_high), 32'd4);

    // Reverse from segment 1, level 1.
    guard = 0;
    while (m_pos != 5 && guard < 200) begin
      step();
      guard++;
    end
    chk("reach_s1l1", 32'(m_pos), 32'd5);
    bus.dir = 1'b1;
    repeat (4) step();
    chk("rev_t1_seg", 32'(bus.hue_seg), 32'd1);
    chk("rev_t1_lvl", 32'(bus.hue_lvl), 32'd0);
    repeat (4) step();
    chk("rev_t2_seg", 32'(bus.hue_seg), 32'd0);
    chk("rev_t2_lvl", 32'(bus.hue_lvl), 32'd3);
    repeat (4) step();
    chk("rev_t3_lvl", 32'(bus.hue_lvl), 32'd2);
    wraps = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.seg_wrap) wraps++;
    end
    chk("rev_wraps", 32'(wraps), 32'd1);
    chk("rev_seg5",  32'(bus.hue_seg), 32'd5);

    // Pause mid-step at segment 0, level 1.
    bus.dir = 1'b0;
    repeat (10) step();
    chk("pause_lvl_pre", 32'(bus.hue_lvl), 32'd1);
    bus.en = 1'b0;
    g_on = 0; g_off = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.RGB_G == 1'b0) g_on++; else g_off++;
    end
    chk("pause_seg", 32'(bus.hue_seg), 32'd0);
    chk("pause_lvl", 32'(bus.hue_lvl), 32'd1);
    chk("pause_g_toggles", 32'((g_on > 0) && (g_off > 0)), 32'd1);
    bus.en = 1'b1;
    step();
    chk("resume_hold", 32'(bus.hue_lvl), 32'd1);
    step();
    chk("resume_step", 32'(bus.hue_lvl), 32'd2);

    // Randomized enable/direction.
    for (int i = 0; i < 400; i++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.dir = ~bus.dir;
      step();
    end

    // Asynchronous reset between edges at segment 3.
    bus.en  = 1'b1;
    bus.dir = 1'b0;
    guard = 0;
    while ((m_pos / LV) != 3 && guard < 200) begin
      step();
      guard++;
    end
    chk("reach_seg3", 32'(bus.hue_seg), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb",  rgb_now(), 32'h7);
    chk("arst_seg",  32'(bus.hue_seg), 32'd0);
    chk("arst_lvl",  32'(bus.hue_lvl), 32'd0);
    chk("arst_wrap", 32'(bus.seg_wrap), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 1) chk("arst_first_rgb", rgb_now(), 32'h3);
      if (e == 4) begin
        chk("arst_e4_seg", 32'(bus.hue_seg), 32'd0);
        chk("arst_e4_lvl", 32'(bus.hue_lvl), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
